oh_demux5_reg: RTL and testbench

- 1-to-5 one-hot stream demultiplexer with a registered output stage.
- Sits upstream of a 5:1 one-hot mux to fan a single valid/ready source out to five consumers, e.g. to distribute requests to five slices whose results are later recombined.
- Each accepted word carries a one-hot destination select. The word is held in a single-entry output register until its selected consumer accepts it.
- Illegal selects are consumed, dropped and flagged.

---
 rtl/oh_demux5_pkg.sv | 18 +
 rtl/oh_demux5_reg_if.sv | 29 ++
 rtl/oh_onehot_chk5.sv | 17 +
 rtl/oh_demux5_reg.sv | 88 ++++++++
 tb/tb_oh_demux5_reg.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/oh_demux5_pkg.sv
// oh_demux5_pkg: shared constants and helpers for the 1-to-5 one-hot demux
// and its matching mux-side checker.
//   NOUT       : number of destinations
//   RR_RESET   : reset value of the auto-route pointer (OH_DEMUX5_RR_EN builds)
//   onehot_chk : 1 when the 5-bit vector has exactly one bit set
package oh_demux5_pkg;

  localparam int NOUT = 5;
  localparam logic [NOUT-1:0] RR_RESET = 5'b00001;

  function automatic logic onehot_chk(input logic [NOUT-1:0] v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < NOUT; i++) cnt = cnt + {2'b00, v[i]};
    return (cnt == 3'd1);
  endfunction

endpackage

// File: rtl/oh_demux5_reg_if.sv
// oh_demux5_reg_if: stream bundle for oh_demux5_reg.
//   in_valid/in_ready/in_sel/in_data : upstream valid/ready word + one-hot select
//   out_valid/out_ready/out_data     : five downstream valid/ready lanes, shared data
//   err_clr/err                      : sticky illegal-select flag and its clear
// Modports: slave = demux side, master = source/sink driver side.
interface oh_demux5_reg_if #(parameter int N = 1);
  import oh_demux5_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [NOUT-1:0] in_sel;
  logic [N-1:0]    in_data;
  logic [NOUT-1:0] out_valid;
  logic [NOUT-1:0] out_ready;
  logic [N-1:0]    out_data;
  logic            err_clr;
  logic            err;

  modport slave (
    input  in_valid, in_sel, in_data, out_ready, err_clr,
    output in_ready, out_valid, out_data, err
  );

  modport master (
    output in_valid, in_sel, in_data, out_ready, err_clr,
    input  in_ready, out_valid, out_data, err
  );

endinterface

// File: rtl/oh_onehot_chk5.sv
// oh_onehot_chk5: combinational 5-bit select classifier, shared with the
// mux-side checker.
//   i_vec    : select vector
//   o_onehot : exactly one bit set
//   o_zero   : no bit set
module oh_onehot_chk5
  import oh_demux5_pkg::*;
(
  input  logic [NOUT-1:0] i_vec,
  output logic            o_onehot,
  output logic            o_zero
);

  assign o_onehot = onehot_chk(i_vec);
  assign o_zero   = (i_vec == '0);

endmodule

// File: rtl/oh_demux5_reg.sv
// oh_demux5_reg: 1-to-5 one-hot stream demux with a single-entry registered
// output stage. Words with an illegal select are consumed, dropped and flag err.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : oh_demux5_reg_if.slave stream bundle (see interface header)
// Parameter N: data width.
// Optional macro OH_DEMUX5_RR_EN: in_sel==0 auto-routes to a rotating one-hot
// pointer; otherwise in_sel==0 is illegal.
module oh_demux5_reg
  import oh_demux5_pkg::*;
#(
  parameter int N = 1
) (
  input  logic                clk,
  input  logic                reset,
  oh_demux5_reg_if.slave      bus
);

  logic            r_full;
  logic [NOUT-1:0] r_sel;
  logic [N-1:0]    r_data;
  logic            r_err;

  logic            w_onehot;
  logic            w_zero;
  logic            w_legal;
  logic [NOUT-1:0] w_sel;
  logic            w_out_fire;
  logic            w_in_ready;
  logic            w_in_fire;

  oh_onehot_chk5 u_chk (
    .i_vec    (bus.in_sel),
    .o_onehot (w_onehot),
    .o_zero   (w_zero)
  );

`ifdef OH_DEMUX5_RR_EN
  logic [NOUT-1:0] r_rr;

  // A zero select takes the pointer's destination.
  assign w_legal = w_onehot | w_zero;
  assign w_sel   = w_zero ? r_rr : bus.in_sel;

  // Pointer advances only on auto-routed words, never on explicit ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_rr <= RR_RESET;
    else if (w_in_fire && w_zero) r_rr <= {r_rr[NOUT-2:0], r_rr[NOUT-1]};
  end
`else
  // o_zero is implied by !o_onehot here; kept so both builds share the checker.
  assign w_legal = w_onehot & ~w_zero;
  assign w_sel   = bus.in_sel;
`endif

  // Unselected out_ready bits are masked off by r_sel.
  assign w_out_fire = r_full & |(r_sel & bus.out_ready);
  // Combinational from out_ready so a draining slot can refill the same cycle.
  assign w_in_ready = ~r_full | w_out_fire;
  assign w_in_fire  = bus.in_valid & w_in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= 1'b0;
      r_sel  <= '0;
      r_data <= '0;
    end else if (w_in_fire && w_legal) begin
      r_full <= 1'b1;
      r_sel  <= w_sel;
      r_data <= bus.in_data;
    end else if (w_out_fire) begin
      // Covers dropped words too: the held word still drains.
      r_full <= 1'b0;
    end
  end

  // Set beats clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      r_err <= 1'b0;
    else if (w_in_fire && !w_legal) r_err <= 1'b1;
    else if (bus.err_clr)           r_err <= 1'b0;
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = {NOUT{r_full}} & r_sel;
  assign bus.out_data  = r_data;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_oh_demux5_reg.sv
module tb_oh_demux5_reg;
  import oh_demux5_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  oh_demux5_reg_if #(.N(N)) bus ();

  oh_demux5_reg #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       vld;
    logic [4:0] sel;
    logic [7:0] dat;
    logic [4:0] rdy;
    logic       clr;
    logic       e_ir;
    logic [4:0] e_ov;
    logic [7:0] e_od;
    logic       e_err;
  } vec_t;

  vec_t vt[18];

  function automatic vec_t mk(logic v, logic [4:0] s, logic [7:0] d, logic [4:0] r,
                              logic c, logic ir, logic [4:0] ov, logic [7:0] od, logic e);
    vec_t x;
    x.vld = v; x.sel = s; x.dat = d; x.rdy = r; x.clr = c;
    x.e_ir = ir; x.e_ov = ov; x.e_od = od; x.e_err = e;
    return x;
  endfunction

  task automatic drive(input logic v, input logic [4:0] s, input logic [7:0] d,
                       input logic [4:0] r, input logic c);
    bus.in_valid = v; bus.in_sel = s; bus.in_data = d; bus.out_ready = r; bus.err_clr = c;
  endtask

  // Inputs change 1 time unit after posedge; outputs are sampled on negedge.
  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  logic [4:0] zsel;
  logic [4:0] exp_rr[8];
  logic [4:0] rr_in[8];

  initial begin
`ifdef OH_DEMUX5_RR_EN
    zsel = 5'b11000;  // zero is legal here; use another illegal pattern
`else
    zsel = 5'b00000;
`endif
    // vld sel dat rdy clr | in_ready out_valid out_data err
    vt[0]  = mk(1, 5'b00100, 8'hA5, 5'b00100, 0, 1, 5'b00000, 8'h00, 0);
    vt[1]  = mk(0, 5'b00000, 8'h00, 5'b00100, 0, 1, 5'b00100, 8'hA5, 0);
    vt[2]  = mk(0, 5'b00000, 8'h00, 5'b00100, 0, 1, 5'b00000, 8'hA5, 0);
    vt[3]  = mk(1, 5'b00001, 8'h11, 5'b00000, 0, 1, 5'b00000, 8'hA5, 0);
    vt[4]  = mk(1, 5'b10000, 8'h22, 5'b00000, 0, 0, 5'b00001, 8'h11, 0);
    vt[5]  = mk(1, 5'b10000, 8'h22, 5'b00000, 0, 0, 5'b00001, 8'h11, 0);
    vt[6]  = mk(1, 5'b10000, 8'h22, 5'b00001, 0, 1, 5'b00001, 8'h11, 0);
    vt[7]  = mk(0, 5'b00000, 8'h00, 5'b10000, 0, 1, 5'b10000, 8'h22, 0);
    vt[8]  = mk(0, 5'b00000, 8'h00, 5'b00000, 0, 1, 5'b00000, 8'h22, 0);
    vt[9]  = mk(1, 5'b00011, 8'h33, 5'b11111, 0, 1, 5'b00000, 8'h22, 0);
    vt[10] = mk(1, zsel,     8'h44, 5'b11111, 1, 1, 5'b00000, 8'h22, 1);
    vt[11] = mk(0, 5'b00000, 8'h00, 5'b00000, 1, 1, 5'b00000, 8'h22, 1);
    vt[12] = mk(0, 5'b00000, 8'h00, 5'b00000, 0, 1, 5'b00000, 8'h22, 0);
    vt[13] = mk(1, 5'b01000, 8'h55, 5'b00000, 0, 1, 5'b00000, 8'h22, 0);
    vt[14] = mk(1, 5'b00101, 8'h66, 5'b01000, 0, 1, 5'b01000, 8'h55, 0);
    vt[15] = mk(0, 5'b00000, 8'h00, 5'b00000, 0, 1, 5'b00000, 8'h55, 1);
    vt[16] = mk(0, 5'b00000, 8'h00, 5'b00000, 1, 1, 5'b00000, 8'h55, 1);
    vt[17] = mk(0, 5'b00000, 8'h00, 5'b00000, 0, 1, 5'b00000, 8'h55, 0);

    drive(0, 5'b0, 8'h0, 5'b0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data",  32'(bus.out_data),  32'h0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'h1);
    chk("rst_err",       32'(bus.err),       32'h0);
    next_cyc();

    // Table vectors: one cycle each.
    for (int i = 0; i < 18; i++) begin
      drive(vt[i].vld, vt[i].sel, vt[i].dat, vt[i].rdy, vt[i].clr);
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i),  32'(bus.in_ready),  32'(vt[i].e_ir));
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vt[i].e_ov));
      chk($sformatf("v%0d_out_data", i),  32'(bus.out_data),  32'(vt[i].e_od));
      chk($sformatf("v%0d_err", i),       32'(bus.err),       32'(vt[i].e_err));
      next_cyc();
    end

    // Streaming: 20 words back-to-back, each visible exactly one cycle later.
    for (int k = 0; k <= 20; k++) begin
      if (k < 20) drive(1, 5'(5'b00001 << (k % 5)), 8'(8'h30 + k), 5'b11111, 0);
      else        drive(0, 5'b0, 8'h0, 5'b11111, 0);
      @(negedge clk);
      chk($sformatf("st%0d_in_ready", k), 32'(bus.in_ready), 32'h1);
      if (k > 0) begin
        chk($sformatf("st%0d_out_valid", k), 32'(bus.out_valid), 32'(5'b00001 << ((k - 1) % 5)));
        chk($sformatf("st%0d_out_data", k),  32'(bus.out_data),  32'(8'h30 + k - 1));
      end
      next_cyc();
    end
    drive(0, 5'b0, 8'h0, 5'b0, 0);
    @(negedge clk);
    chk("st_drained", 32'(bus.out_valid), 32'h0);
    next_cyc();

    // Wrong-ready: only non-selected lanes ready; the word must stay put.
    drive(1, 5'b00010, 8'h77, 5'b11101, 0);
    next_cyc();
    drive(1, 5'b00100, 8'h88, 5'b11101, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("wr%0d_out_valid", k), 32'(bus.out_valid), 32'h02);
      chk($sformatf("wr%0d_out_data", k),  32'(bus.out_data),  32'h77);
      chk($sformatf("wr%0d_in_ready", k),  32'(bus.in_ready),  32'h0);
      next_cyc();
    end
    drive(0, 5'b0, 8'h0, 5'b00010, 0);
    @(negedge clk);
    chk("wr_release_in_ready", 32'(bus.in_ready), 32'h1);
    next_cyc();
    @(negedge clk);
    chk("wr_after_out_valid", 32'(bus.out_valid), 32'h0);
    next_cyc();

    // Reset mid-transfer drops the held word immediately.
    drive(1, 5'b00100, 8'h99, 5'b00000, 0);
    next_cyc();
    drive(0, 5'b0, 8'h0, 5'b00000, 0);
    @(negedge clk);
    chk("mr_held", 32'(bus.out_valid), 32'h04);
    #1 reset = 1'b1;
    #1;
    chk("mr_out_valid", 32'(bus.out_valid), 32'h0);
    chk("mr_out_data",  32'(bus.out_data),  32'h0);
    chk("mr_in_ready",  32'(bus.in_ready),  32'h1);
    next_cyc();
    reset = 1'b0;

`ifdef OH_DEMUX5_RR_EN
    // Auto-route: three auto, one explicit to lane 3, then four auto.
    rr_in  = '{5'b0, 5'b0, 5'b0, 5'b01000, 5'b0, 5'b0, 5'b0, 5'b0};
    exp_rr = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b10000, 5'b00001, 5'b00010};
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) drive(1, rr_in[k], 8'(8'hC0 + k), 5'b11111, 0);
      else       drive(0, 5'b0, 8'h0, 5'b11111, 0);
      @(negedge clk);
      if (k > 0) begin
        chk($sformatf("rr%0d_out_valid", k), 32'(bus.out_valid), 32'(exp_rr[k - 1]));
        chk($sformatf("rr%0d_out_data", k),  32'(bus.out_data),  32'(8'hC0 + k - 1));
        chk($sformatf("rr%0d_err", k),       32'(bus.err),       32'h0);
      end
      next_cyc();
    end
`else
    // Zero select is illegal here: no output, err raised.
    rr_in  = '{default: 5'b0};
    exp_rr = '{default: 5'b0};
    drive(1, rr_in[0], 8'hEE, 5'b11111, 0);
    next_cyc();
    drive(0, 5'b0, 8'h0, 5'b11111, 0);
    @(negedge clk);
    chk("zsel_out_valid", 32'(bus.out_valid), 32'(exp_rr[0]));
    chk("zsel_err",       32'(bus.err),       32'h1);
    next_cyc();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
